// File: rtl/cubic_acc_ctrl.sv
// Tile sequencer for the 8-lane cubic accumulation buffer array.
//
// Accepts one tile configuration at a time and latches the output-map geometry. It then counts
// cube-unit psum beats per input-channel pass, sequences quantisation and pooling, and counts
// returned results until the tile is complete.
//
// Ports:
//   clock, rst             clock, asynchronous active-high reset
//   cfg_*                  configuration handshake and tile geometry
//   cube_psums_valid       psum beat from the cube unit
//   buf_res_valid          result beat returned by the buffer array
//   new_tile, one_buf_end, qtf_start, pooling_start, tile_done, cfg_err
//                          registered one-cycle pulses
//   psums_valid            psum strobe to the buffer array, gated to the accumulate phase
//   busy                   tile in flight
//   seq_err                sticky, set by a psum beat outside the accumulate phase
module cubic_acc_ctrl #(
  parameter int unsigned QTF_LAT  = 4,
  parameter int unsigned MAX_PASS = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_tile_height,
  input  logic [5:0] cfg_tile_length,
  input  logic [2:0] cfg_ksize,
  input  logic [2:0] cfg_stride,
  input  logic [1:0] cfg_pool_size,
  input  logic [4:0] cfg_passes,
  input  logic       cube_psums_valid,
  input  logic       buf_res_valid,
  output logic       new_tile,
  output logic       psums_valid,
  output logic       one_buf_end,
  output logic       qtf_start,
  output logic       pooling_start,
  output logic       busy,
  output logic       tile_done,
  output logic       cfg_err,
  output logic       seq_err
);

  localparam logic [5:0] MaxPass = 6'(MAX_PASS);
  localparam logic [3:0] QtfLat  = 4'(QTF_LAT);

  typedef enum logic [1:0] {StIdle, StAcc, StQtf, StDrain} state_e;

  state_e      state_q, state_d;
  logic [11:0] beat_cnt_q, beat_cnt_d;
  logic [4:0]  pass_cnt_q, pass_cnt_d;
  logic [11:0] res_cnt_q, res_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [11:0] bpp_q, bpp_d;
  logic [11:0] exp_res_q, exp_res_d;
  logic [4:0]  passes_q, passes_d;
  logic        pool_en_q, pool_en_d;
  logic        new_tile_q, new_tile_d;
  logic        one_buf_end_q, one_buf_end_d;
  logic        qtf_start_q, qtf_start_d;
  logic        pooling_start_q, pooling_start_d;
  logic        tile_done_q, tile_done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        seq_err_q, seq_err_d;

  // Geometry of the offered configuration; only meaningful when cfg_bad is low.
  logic [2:0]  stride_nz;
  logic [5:0]  diff_h, diff_w, out_h, out_w, pool_h, pool_w;
  logic [11:0] bpp_c, exp_res_c;
  logic        cfg_bad;

  always_comb begin
    stride_nz = (cfg_stride == 3'd0) ? 3'd1 : cfg_stride;  // keeps the divider defined
    diff_h    = cfg_tile_height - {3'b000, cfg_ksize};
    diff_w    = cfg_tile_length - {3'b000, cfg_ksize};
    out_h     = diff_h / {3'b000, stride_nz} + 6'd1;
    out_w     = diff_w / {3'b000, stride_nz} + 6'd1;
    pool_h    = out_h >> cfg_pool_size;
    pool_w    = out_w >> cfg_pool_size;
    bpp_c     = {6'd0, out_h} * {6'd0, out_w};
    exp_res_c = {6'd0, pool_h} * {6'd0, pool_w};
    cfg_bad   = (cfg_ksize == 3'd0) || (cfg_stride == 3'd0) ||
                ({3'b000, cfg_ksize} > cfg_tile_height) ||
                ({3'b000, cfg_ksize} > cfg_tile_length) ||
                (cfg_pool_size == 2'd3) || (cfg_passes == 5'd0) ||
                ({1'b0, cfg_passes} > MaxPass) || (exp_res_c == 12'd0);
  end

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    pass_cnt_d      = pass_cnt_q;
    res_cnt_d       = res_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    bpp_d           = bpp_q;
    exp_res_d       = exp_res_q;
    passes_d        = passes_q;
    pool_en_d       = pool_en_q;
    new_tile_d      = 1'b0;
    one_buf_end_d   = 1'b0;
    qtf_start_d     = 1'b0;
    pooling_start_d = 1'b0;
    tile_done_d     = 1'b0;
    cfg_err_d       = 1'b0;
    seq_err_d       = seq_err_q;

    if (cube_psums_valid && (state_q != StAcc)) seq_err_d = 1'b1;
    // Results count from accept onwards so early returns during QTF are not lost.
    if (buf_res_valid && (state_q != StIdle)) res_cnt_d = res_cnt_q + 12'd1;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d    = StAcc;
            new_tile_d = 1'b1;
            seq_err_d  = 1'b0;
            beat_cnt_d = '0;
            pass_cnt_d = '0;
            res_cnt_d  = '0;
            wait_cnt_d = '0;
            bpp_d      = bpp_c;
            exp_res_d  = exp_res_c;
            passes_d   = cfg_passes;
            pool_en_d  = (cfg_pool_size != 2'd0);
          end
        end
      end
      StAcc: begin
        if (cube_psums_valid) begin
          if (beat_cnt_q == bpp_q - 12'd1) begin
            beat_cnt_d    = '0;
            one_buf_end_d = 1'b1;
            pass_cnt_d    = pass_cnt_q + 5'd1;
            if (pass_cnt_q + 5'd1 == passes_q) begin
              state_d    = StQtf;
              wait_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 12'd1;
          end
        end
      end
      StQtf: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == 4'd0) begin
          qtf_start_d = 1'b1;
          if (!pool_en_q) state_d = StDrain;
        end else if (wait_cnt_q == QtfLat) begin
          pooling_start_d = 1'b1;
          state_d         = StDrain;
        end
      end
      StDrain: begin
        if (res_cnt_d >= exp_res_q) begin
          tile_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      beat_cnt_q      <= '0;
      pass_cnt_q      <= '0;
      res_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      bpp_q           <= '0;
      exp_res_q       <= '0;
      passes_q        <= '0;
      pool_en_q       <= 1'b0;
      new_tile_q      <= 1'b0;
      one_buf_end_q   <= 1'b0;
      qtf_start_q     <= 1'b0;
      pooling_start_q <= 1'b0;
      tile_done_q     <= 1'b0;
      cfg_err_q       <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      pass_cnt_q      <= pass_cnt_d;
      res_cnt_q       <= res_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      bpp_q           <= bpp_d;
      exp_res_q       <= exp_res_d;
      passes_q        <= passes_d;
      pool_en_q       <= pool_en_d;
      new_tile_q      <= new_tile_d;
      one_buf_end_q   <= one_buf_end_d;
      qtf_start_q     <= qtf_start_d;
      pooling_start_q <= pooling_start_d;
      tile_done_q     <= tile_done_d;
      cfg_err_q       <= cfg_err_d;
      seq_err_q       <= seq_err_d;
    end
  end

  always_comb begin
    cfg_ready     = (state_q == StIdle);
    busy          = (state_q != StIdle);
    psums_valid   = cube_psums_valid && (state_q == StAcc);
    new_tile      = new_tile_q;
    one_buf_end   = one_buf_end_q;
    qtf_start     = qtf_start_q;
    pooling_start = pooling_start_q;
    tile_done     = tile_done_q;
    cfg_err       = cfg_err_q;
    seq_err       = seq_err_q;
  end

endmodule

// File: tb/tb_cubic_acc_ctrl.sv
module tb_cubic_acc_ctrl;

  localparam int QtfLat = 4;

  localparam int EvNewTile = 0;
  localparam int EvObe     = 1;
  localparam int EvQtf     = 2;
  localparam int EvPool    = 3;
  localparam int EvDone    = 4;
  localparam int EvCfgErr  = 5;

  logic       clock = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [5:0] cfg_tile_height, cfg_tile_length;
  logic [2:0] cfg_ksize, cfg_stride;
  logic [1:0] cfg_pool_size;
  logic [4:0] cfg_passes;
  logic       cube_psums_valid, buf_res_valid;
  logic       new_tile, psums_valid, one_buf_end, qtf_start, pooling_start;
  logic       busy, tile_done, cfg_err, seq_err;

  cubic_acc_ctrl #(
    .QTF_LAT (QtfLat),
    .MAX_PASS(16)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_tile_height (cfg_tile_height),
    .cfg_tile_length (cfg_tile_length),
    .cfg_ksize       (cfg_ksize),
    .cfg_stride      (cfg_stride),
    .cfg_pool_size   (cfg_pool_size),
    .cfg_passes      (cfg_passes),
    .cube_psums_valid(cube_psums_valid),
    .buf_res_valid   (buf_res_valid),
    .new_tile        (new_tile),
    .psums_valid     (psums_valid),
    .one_buf_end     (one_buf_end),
    .qtf_start       (qtf_start),
    .pooling_start   (pooling_start),
    .busy            (busy),
    .tile_done       (tile_done),
    .cfg_err         (cfg_err),
    .seq_err         (seq_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  // h, l, k, s, pool, passes, beat gap, result delay, stray beat in DRAIN, accepted,
  // beats per pass, expected results
  typedef struct {
    int h;
    int l;
    int k;
    int s;
    int pool;
    int passes;
    int gap;
    int res_delay;
    bit stray;
    bit ok;
    int bpp;
    int er;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t ev;
    ev.kind = kind;
    ev.cyc  = c;
    exp_q.push_back(ev);
  endtask

  // Scoreboard: every pulse the DUT raises must match the head of the expected queue.
  always @(negedge clock) begin
    int n;
    int kind;
    ev_t ev;
    if (rst === 1'b0) begin
      n = int'(new_tile) + int'(one_buf_end) + int'(qtf_start) + int'(pooling_start) +
          int'(tile_done) + int'(cfg_err);
      kind = new_tile ? EvNewTile : one_buf_end ? EvObe : qtf_start ? EvQtf :
             pooling_start ? EvPool : tile_done ? EvDone : EvCfgErr;
      if (n > 1) begin
        chk("pulse_overlap", n, 1);
      end else if (n == 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_kind", kind, -1);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", kind, ev.kind);
          chk("pulse_cycle", cyc, ev.cyc);
        end
      end
    end
  end

  task automatic idle_inputs();
    cfg_valid        = 1'b0;
    cube_psums_valid = 1'b0;
    buf_res_valid    = 1'b0;
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_tile_height = 6'(v.h);
    cfg_tile_length = 6'(v.l);
    cfg_ksize       = 3'(v.k);
    cfg_stride      = 3'(v.s);
    cfg_pool_size   = 2'(v.pool);
    cfg_passes      = 5'(v.passes);
    cfg_valid       = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int a, total, e, drain, r0, rlast, done, last_beat;
    bit beat;
    @(posedge clock); #1;
    a = cyc;
    drive_cfg(v);
    if (!v.ok) begin
      push(EvCfgErr, a + 1);
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      @(negedge clock);
      chk("rej_cfg_ready", cfg_ready, 1);
      chk("rej_busy", busy, 0);
      repeat (3) @(posedge clock);
      chk("rej_queue_empty", exp_q.size(), 0);
      return;
    end
    total     = v.passes * v.bpp;
    last_beat = a + 1 + (total - 1) * v.gap;
    e         = last_beat + 1;
    push(EvNewTile, a + 1);
    for (int p = 0; p < v.passes; p++) push(EvObe, a + 1 + ((p + 1) * v.bpp - 1) * v.gap + 1);
    push(EvQtf, e + 1);
    if (v.pool != 0) begin
      push(EvPool, e + 1 + QtfLat);
      drain = e + 1 + QtfLat;
    end else begin
      drain = e + 1;
    end
    r0    = e + 1 + v.res_delay;
    rlast = r0 + v.er - 1;
    done  = ((rlast > drain) ? rlast : drain) + 1;
    push(EvDone, done);
    for (int c = a + 1; c <= done + 1; c++) begin
      @(posedge clock); #1;
      cfg_valid        = 1'b0;
      beat             = (c <= last_beat) && ((c - a - 1) % v.gap == 0);
      cube_psums_valid = beat || (v.stray && c == drain);
      buf_res_valid    = (c >= r0) && (c <= rlast);
      @(negedge clock);
      if (beat) chk("psums_passthrough", psums_valid, 1);
      if (v.stray && c == drain) chk("psums_gated_drain", psums_valid, 0);
      if (v.stray && c == drain + 1) chk("seq_err_set_drain", seq_err, 1);
      if (c == a + 1) begin
        chk("busy_after_accept", busy, 1);
        chk("cfg_ready_after_accept", cfg_ready, 0);
        chk("seq_err_cleared_on_accept", seq_err, 0);
      end
      if (c == done) begin
        chk("busy_at_done", busy, 0);
        chk("cfg_ready_at_done", cfg_ready, 1);
        if (v.stray) chk("seq_err_sticky", seq_err, 1);
      end
    end
    idle_inputs();
    chk("tile_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6, 6, 3, 1, 1, 2, 1, 0, 1'b0, 1'b1, 16, 4};
    vecs[1]  = '{8, 8, 3, 2, 0, 1, 1, 2, 1'b0, 1'b1, 9, 9};
    vecs[2]  = '{4, 8, 5, 1, 0, 1, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{5, 7, 2, 1, 0, 3, 3, 0, 1'b1, 1'b1, 24, 24};
    vecs[4]  = '{8, 8, 3, 1, 0, 1, 1, 0, 1'b0, 1'b1, 36, 36};
    vecs[5]  = '{8, 8, 1, 1, 2, 1, 2, 1, 1'b0, 1'b1, 64, 4};
    vecs[6]  = '{6, 6, 3, 1, 3, 1, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[7]  = '{6, 6, 3, 1, 0, 0, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{6, 6, 3, 1, 0, 17, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{6, 6, 3, 0, 0, 1, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{5, 5, 3, 1, 2, 1, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[11] = '{6, 6, 0, 1, 0, 1, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[12] = '{3, 3, 3, 1, 0, 16, 1, 0, 1'b0, 1'b1, 1, 1};
    vecs[13] = '{20, 15, 7, 7, 0, 1, 1, 0, 1'b0, 1'b1, 4, 4};
    vecs[14] = '{8, 6, 4, 1, 1, 2, 2, 3, 1'b0, 1'b1, 15, 2};
    vecs[15] = '{8, 4, 5, 1, 0, 1, 1, 0, 1'b0, 1'b0, 0, 0};

    rst = 1'b1;
    idle_inputs();
    drive_cfg(vecs[0]);
    cfg_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs",
        int'({new_tile, psums_valid, one_buf_end, qtf_start, pooling_start, busy, tile_done,
              cfg_err, seq_err, cfg_ready}), 1);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("post_reset_cfg_ready", cfg_ready, 1);
    chk("post_reset_busy", busy, 0);

    // Stray psum beat while idle: gated off and latched as a sequence error.
    @(posedge clock); #1;
    cube_psums_valid = 1'b1;
    @(negedge clock);
    chk("psums_gated_idle", psums_valid, 0);
    @(posedge clock); #1;
    cube_psums_valid = 1'b0;
    @(negedge clock);
    chk("seq_err_set_idle", seq_err, 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("seq_err_held_idle", seq_err, 1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset part-way through the first pass: no pass end, no completion, clean restart.
    begin
      int a;
      @(posedge clock); #1;
      a = cyc;
      drive_cfg(vecs[0]);
      push(EvNewTile, a + 1);
      for (int c = a + 1; c <= a + 10; c++) begin
        @(posedge clock); #1;
        cfg_valid        = 1'b0;
        cube_psums_valid = 1'b1;
      end
      @(posedge clock); #1;
      rst = 1'b1;
      #1;
      chk("midtile_reset_outputs",
          int'({new_tile, psums_valid, one_buf_end, qtf_start, pooling_start, busy, tile_done,
                cfg_err, seq_err, cfg_ready}), 1);
      cube_psums_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b0;
      chk("midtile_queue_empty", exp_q.size(), 0);
      repeat (3) @(posedge clock);
      chk("midtile_no_stray_pulse", exp_q.size(), 0);
    end
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
